// File: rtl/wheel_encoder_cm.sv
// Quadrature wheel encoder to signed, wrapping centimetre count.
// Optional glitch filter on the synchronised phases: define ENC_GLITCH_FILTER_EN.
module wheel_encoder_cm #(
    parameter int unsigned TICKS_PER_CM  = 12,
    parameter int unsigned FILTER_CYCLES = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        encoder_reset,
    output logic [31:0] encoder_in_cm,
    output logic        cm_strobe,
    output logic        moving_reverse,
    output logic        quad_error
);

    if (TICKS_PER_CM < 2 || TICKS_PER_CM > 255 || FILTER_CYCLES < 2 || FILTER_CYCLES > 255) begin : g_bad_params
        $error("wheel_encoder_cm: parameter out of range");
    end

`ifdef ENC_GLITCH_FILTER_EN
    localparam int unsigned WARMUP = FILTER_CYCLES + 3;
`else
    localparam int unsigned WARMUP = 3;
`endif
    localparam int unsigned WU_W = $clog2(WARMUP + 1);
    localparam logic signed [8:0] ACC_MAX = 9'(TICKS_PER_CM - 1);
    localparam logic signed [8:0] ACC_MIN = -ACC_MAX;

    logic            a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [1:0]      q, dec, prev_q;
    logic [WU_W-1:0] wu_q, wu_d;
    logic            warm;
    logic            step_fwd, step_rev, step_bad;
    logic [31:0]     cm_q, cm_d;
    logic signed [8:0] acc_q, acc_d;
    logic            strobe_q, strobe_d;
    logic            rev_q, rev_d;
    logic            err_q, err_d;

    assign q = {a_s2_q, b_s2_q};

`ifdef ENC_GLITCH_FILTER_EN
    logic [1:0] f_q, f_d, ql_q;
    logic [7:0] fcnt_q, fcnt_d;

    // fcnt counts consecutive cycles q has held a value different from f
    always_comb begin
        f_d    = f_q;
        fcnt_d = fcnt_q;
        if (q == f_q) begin
            fcnt_d = '0;
        end else if (q != ql_q) begin
            fcnt_d = 8'd1;
        end else if (fcnt_q == 8'(FILTER_CYCLES - 1)) begin
            f_d    = q;
            fcnt_d = '0;
        end else begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            f_q    <= '0;
            ql_q   <= '0;
            fcnt_q <= '0;
        end else begin
            f_q    <= f_d;
            ql_q   <= q;
            fcnt_q <= fcnt_d;
        end
    end

    assign dec = f_q;
`else
    assign dec = q;
`endif

    assign warm = (wu_q == WU_W'(WARMUP));

    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        step_bad = 1'b0;
        case ({prev_q, dec})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cm_d     = cm_q;
        acc_d    = acc_q;
        strobe_d = 1'b0;
        rev_d    = rev_q;
        err_d    = err_q;
        wu_d     = warm ? wu_q : wu_q + WU_W'(1);
        if (encoder_reset) begin
            cm_d  = '0;
            acc_d = '0;
            err_d = 1'b0;
        end else if (warm) begin
            if (step_bad) err_d = 1'b1;
            if (step_fwd) begin
                rev_d = 1'b0;
                if (acc_q == ACC_MAX) begin
                    acc_d    = '0;
                    cm_d     = cm_q + 32'd1;
                    strobe_d = 1'b1;
                end else begin
                    acc_d = acc_q + 9'sd1;
                end
            end
            if (step_rev) begin
                rev_d = 1'b1;
                if (acc_q == ACC_MIN) begin
                    acc_d    = '0;
                    cm_d     = cm_q - 32'd1;
                    strobe_d = 1'b1;
                end else begin
                    acc_d = acc_q - 9'sd1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            a_s1_q   <= 1'b0;
            a_s2_q   <= 1'b0;
            b_s1_q   <= 1'b0;
            b_s2_q   <= 1'b0;
            prev_q   <= '0;
            wu_q     <= '0;
            cm_q     <= '0;
            acc_q    <= '0;
            strobe_q <= 1'b0;
            rev_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_s1_q   <= enc_a;
            a_s2_q   <= a_s1_q;
            b_s1_q   <= enc_b;
            b_s2_q   <= b_s1_q;
            prev_q   <= dec;
            wu_q     <= wu_d;
            cm_q     <= cm_d;
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
            rev_q    <= rev_d;
            err_q    <= err_d;
        end
    end

    assign encoder_in_cm  = cm_q;
    assign cm_strobe      = strobe_q;
    assign moving_reverse = rev_q;
    assign quad_error     = err_q;

endmodule

// File: tb/tb_wheel_encoder_cm.sv
// Directed self-checking bench for wheel_encoder_cm (TICKS_PER_CM=12, FILTER_CYCLES=16).
module tb_wheel_encoder_cm;

`ifdef ENC_GLITCH_FILTER_EN
    localparam int FL  = 16;
    localparam int GAP = 30;
`else
    localparam int FL  = 0;
    localparam int GAP = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enc_a, enc_b;
    logic        encoder_reset;
    logic [31:0] cm;
    logic        cm_strobe, moving_reverse, quad_error;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;
    int ph = 0;
    int s0;

    wheel_encoder_cm #(.TICKS_PER_CM(12), .FILTER_CYCLES(16)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .enc_a         (enc_a),
        .enc_b         (enc_b),
        .encoder_reset (encoder_reset),
        .encoder_in_cm (cm),
        .cm_strobe     (cm_strobe),
        .moving_reverse(moving_reverse),
        .quad_error    (quad_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cm_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Phase index 0..3 maps to {a,b} = 00,01,11,10 (forward order)
    task automatic drive_ph();
        case (ph & 3)
            0: {enc_a, enc_b} = 2'b00;
            1: {enc_a, enc_b} = 2'b01;
            2: {enc_a, enc_b} = 2'b11;
            default: {enc_a, enc_b} = 2'b10;
        endcase
    endtask

    task automatic step(input int dir, input int gap);
        ph = (ph + dir) & 3;
        drive_ph();
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic walk(input int dir, input int n, input int gap);
        for (int i = 0; i < n; i++) step(dir, gap);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        encoder_reset = 1'b0;
        ph = 0;
        drive_ph();
        cycles(3);
        check("rst_cm", cm, 32'h0);
        check("rst_strobe", 32'(cm_strobe), 32'h0);
        check("rst_rev", 32'(moving_reverse), 32'h0);
        check("rst_err", 32'(quad_error), 32'h0);
        rst_n = 1'b1;
        cycles(40);
        check("idle_cm", cm, 32'h0);

        // 48 forward edges, 100 cycles apart
        s0 = strobe_cnt;
        for (int i = 1; i <= 48; i++) begin
            step(1, 100);
            if (i % 12 == 0) check("fwd48_partial", cm, 32'(i / 12));
        end
        check("fwd48_strobes", 32'(strobe_cnt - s0), 32'd4);
        check("fwd48_rev", 32'(moving_reverse), 32'h0);
        check("fwd48_err", 32'(quad_error), 32'h0);

        // Clear, then 30 forward / 30 reverse
        encoder_reset = 1'b1;
        cycles(1);
        encoder_reset = 1'b0;
        cycles(2);
        check("clr_cm", cm, 32'h0);
        walk(1, 12, GAP);
        check("fr_f12", cm, 32'd1);
        walk(1, 18, GAP);
        check("fr_f30", cm, 32'd2);
        walk(-1, 18, GAP);
        check("fr_r18", cm, 32'd1);
        walk(-1, 11, GAP);
        check("fr_r29", cm, 32'd1);
        step(-1, 0);
        cycles(2 + FL);
        check("lat_before", cm, 32'd1);
        cycles(1);
        check("lat_at_cm", cm, 32'd0);
        check("lat_at_strobe", 32'(cm_strobe), 32'h1);
        cycles(1);
        check("lat_strobe_1cyc", 32'(cm_strobe), 32'h0);
        check("fr_rev", 32'(moving_reverse), 32'h1);
        cycles(GAP);

        // Wrap below zero and past 0x7FFFFFFF
        rst_n = 1'b0;
        cycles(2);
        check("rst2_cm", cm, 32'h0);
        check("rst2_rev", 32'(moving_reverse), 32'h0);
        rst_n = 1'b1;
        cycles(40);
        walk(-1, 12, GAP);
        check("wrap_neg", cm, 32'hFFFF_FFFF);
        check("wrap_neg_rev", 32'(moving_reverse), 32'h1);
        force dut.cm_q = 32'h7FFF_FFFF;
        cycles(1);
        release dut.cm_q;
        cycles(1);
        check("preload", cm, 32'h7FFF_FFFF);
        walk(1, 12, GAP);
        check("wrap_pos", cm, 32'h8000_0000);
        check("wrap_pos_rev", 32'(moving_reverse), 32'h0);

        // Illegal 00 -> 11
        ph = 2;
        drive_ph();
        cycles(2 + FL);
        check("qerr_before", 32'(quad_error), 32'h0);
        cycles(1);
        check("qerr_set", 32'(quad_error), 32'h1);
        check("qerr_cm", cm, 32'h8000_0000);
        cycles(GAP);
        check("qerr_sticky", 32'(quad_error), 32'h1);
        encoder_reset = 1'b1;
        cycles(1);
        encoder_reset = 1'b0;
        check("qerr_clr", 32'(quad_error), 32'h0);
        check("qerr_clr_cm", cm, 32'h0);

        // Motion while encoder_reset is held
        s0 = strobe_cnt;
        encoder_reset = 1'b1;
        walk(1, 21, GAP);
        check("hold_cm", cm, 32'h0);
        encoder_reset = 1'b0;
        cycles(GAP);
        check("hold_rel_cm", cm, 32'h0);
        check("hold_strobes", 32'(strobe_cnt - s0), 32'h0);
        walk(1, 12, GAP);
        check("hold_after_f12", cm, 32'd1);

`ifdef ENC_GLITCH_FILTER_EN
        // Sub-cm at -11 with inputs 00, so a reverse A glitch would drop the count
        walk(-1, 11, GAP);
        check("flt_pre_cm", cm, 32'd1);
        s0 = strobe_cnt;
        enc_a = 1'b1;
        cycles(5);
        enc_a = 1'b0;
        cycles(40);
        check("flt_glitch_cm", cm, 32'd1);
        check("flt_glitch_strobes", 32'(strobe_cnt - s0), 32'h0);
        step(-1, 0);
        cycles(18);
        check("flt_lat_before", cm, 32'd1);
        cycles(1);
        check("flt_lat_at", cm, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
